// File: rtl/mc_control_fsm.sv
// Multi-cycle Moore control FSM for the shared single-memory/single-ALU datapath.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes trap instead of acting as a NOP).
module mc_control_fsm #(
    parameter int              OPW      = 6,
    parameter int              ALUC_W   = 3,
    parameter logic [OPW-1:0]  OP_RTYPE = 6'h00,
    parameter logic [OPW-1:0]  OP_LW    = 6'h23,
    parameter logic [OPW-1:0]  OP_SW    = 6'h2B,
    parameter logic [OPW-1:0]  OP_BEQ   = 6'h04,
    parameter logic [OPW-1:0]  OP_ADDI  = 6'h08,
    parameter logic [OPW-1:0]  OP_J     = 6'h02
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    Opcode,
    input  logic              mem_ready,
    output logic              BR_En,
    output logic [ALUC_W-1:0] AluC,
    output logic              EnW,
    output logic              EnR,
    output logic              Mux1,
    output logic              regDest,
    output logic              AluSRC,
    output logic              Branch,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic              IorD,
    output logic [1:0]        PCSrc,
    output logic              instr_done,
    output logic [3:0]        state_o,
    output logic              illegal
);

    localparam logic [ALUC_W-1:0] ALU_FUNCT = ALUC_W'(3'b000);
    localparam logic [ALUC_W-1:0] ALU_ADD   = ALUC_W'(3'b001);
    localparam logic [ALUC_W-1:0] ALU_SUB   = ALUC_W'(3'b010);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        R_EXEC   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BR_EXEC  = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        JUMP     = 4'd12,
        TRAP     = 4'd13
    } state_t;

    state_t state_r;
    state_t state_next_s;
    state_t bad_op_s;

    // Destination for an opcode the decoder does not recognise.
    always_comb begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        bad_op_s = TRAP;
`else
        bad_op_s = FETCH;
`endif
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode (FETCH/MEM_* outputs qualified by mem_ready).
    always_comb begin
        state_next_s = state_r;
        BR_En        = 1'b0;
        AluC         = ALU_FUNCT;
        EnW          = 1'b0;
        EnR          = 1'b0;
        Mux1         = 1'b0;
        regDest      = 1'b0;
        AluSRC       = 1'b0;
        Branch       = 1'b0;
        PCWrite      = 1'b0;
        IRWrite      = 1'b0;
        IorD         = 1'b0;
        PCSrc        = 2'b00;
        instr_done   = 1'b0;
        illegal      = 1'b0;
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
            end
            FETCH: begin
                EnR  = 1'b1;
                AluC = ALU_ADD;
                if (mem_ready) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                AluC = ALU_ADD;
                if (Opcode == OP_RTYPE) begin
                    state_next_s = R_EXEC;
                end else if ((Opcode == OP_LW) || (Opcode == OP_SW)) begin
                    state_next_s = MEM_ADDR;
                end else if (Opcode == OP_BEQ) begin
                    state_next_s = BR_EXEC;
                end else if (Opcode == OP_ADDI) begin
                    state_next_s = I_EXEC;
                end else if (Opcode == OP_J) begin
                    state_next_s = JUMP;
                end else begin
                    state_next_s = bad_op_s;
                end
            end
            R_EXEC: begin
                state_next_s = R_WB;
            end
            R_WB: begin
                BR_En        = 1'b1;
                regDest      = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            MEM_ADDR: begin
                AluC   = ALU_ADD;
                AluSRC = 1'b1;
                if (Opcode == OP_LW) begin
                    state_next_s = MEM_RD;
                end else if (Opcode == OP_SW) begin
                    state_next_s = MEM_WR;
                end else begin
                    state_next_s = bad_op_s;
                end
            end
            MEM_RD: begin
                EnR  = 1'b1;
                IorD = 1'b1;
                if (mem_ready) begin
                    state_next_s = MEM_WB;
                end else begin
                    state_next_s = MEM_RD;
                end
            end
            MEM_WB: begin
                BR_En        = 1'b1;
                Mux1         = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            MEM_WR: begin
                EnW  = 1'b1;
                IorD = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEM_WR;
                end
            end
            BR_EXEC: begin
                AluC         = ALU_SUB;
                Branch       = 1'b1;
                PCSrc        = 2'b01;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            I_EXEC: begin
                AluC         = ALU_ADD;
                AluSRC       = 1'b1;
                state_next_s = I_WB;
            end
            I_WB: begin
                BR_En        = 1'b1;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
            JUMP: begin
                PCWrite      = 1'b1;
                PCSrc        = 2'b10;
                instr_done   = 1'b1;
                state_next_s = FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP: begin
                illegal      = 1'b1;
                state_next_s = TRAP;
            end
`endif
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    assign state_o = state_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       BR_En, EnW, EnR, Mux1, regDest, AluSRC, Branch, PCWrite, IRWrite, IorD;
    logic       instr_done, illegal;
    logic [2:0] AluC;
    logic [1:0] PCSrc;
    logic [3:0] state_o;

    mc_control_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .BR_En      (BR_En),
        .AluC       (AluC),
        .EnW        (EnW),
        .EnR        (EnR),
        .Mux1       (Mux1),
        .regDest    (regDest),
        .AluSRC     (AluSRC),
        .Branch     (Branch),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .PCSrc      (PCSrc),
        .instr_done (instr_done),
        .state_o    (state_o),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: BR_En, AluC[2:0], EnW, EnR, Mux1, regDest, AluSRC, Branch, PCWrite, IRWrite, IorD, PCSrc[1:0], instr_done, illegal
    logic [16:0] act;
    assign act = {BR_En, AluC, EnW, EnR, Mux1, regDest, AluSRC, Branch,
                  PCWrite, IRWrite, IorD, PCSrc, instr_done, illegal};

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_R_EXEC = 4'd3,
                           S_R_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
                           S_MEM_WR = 4'd8, S_BR_EXEC = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
                           S_JUMP = 4'd12, S_TRAP = 4'd13;

    //                                   BR  AluC    EnW   EnR   Mux1  rD    ASrc  Br    PCW   IRW   IorD  PCSrc  done  ill
    localparam logic [16:0] O_ZERO    = {1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_FETCH_W = {1'b0,3'b001,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_FETCH_R = {1'b0,3'b001,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_DECODE  = {1'b0,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_R_WB    = {1'b1,3'b000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [16:0] O_ADDSRC  = {1'b0,3'b001,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_MEM_RD  = {1'b0,3'b000,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_MEM_WB  = {1'b1,3'b000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [16:0] O_MEM_WR_W= {1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0};
    localparam logic [16:0] O_MEM_WR_R= {1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,1'b0};
    localparam logic [16:0] O_BR      = {1'b0,3'b010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,1'b1,1'b0};
    localparam logic [16:0] O_I_WB    = {1'b1,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [16:0] O_JUMP    = {1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b10,1'b1,1'b0};
    localparam logic [16:0] O_TRAP    = {1'b0,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1};

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: the DUT presents a Moore output every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ((state_o !== e.st) || (act !== e.o)) begin
                errors++;
                $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
                         e.name, state_o, act, e.st, e.o);
            end
            checks++;
            if (EnR && EnW) begin
                errors++;
                $display("FAIL %s_rw_excl: EnR=%b EnW=%b, expected not both 1", e.name, EnR, EnW);
            end
        end
    end

    task automatic step(input logic r, input logic m, input logic [5:0] op,
                        input logic [3:0] st, input logic [16:0] o, input string nm);
        exp_t e;
        rst_n     = r;
        mem_ready = m;
        Opcode    = op;
        e.name = nm;
        e.st   = st;
        e.o    = o;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        Opcode    = 6'h00;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1, 6'h00, S_IDLE,     O_ZERO,     "reset_idle");
        step(1'b1, 1'b1, 6'h00, S_IDLE,     O_ZERO,     "release_idle");
        // R-type: done in 4th cycle after FETCH entry
        step(1'b1, 1'b1, 6'h00, S_FETCH,    O_FETCH_R,  "r_fetch");
        step(1'b1, 1'b1, 6'h00, S_DECODE,   O_DECODE,   "r_decode");
        step(1'b1, 1'b1, 6'h00, S_R_EXEC,   O_ZERO,     "r_exec");
        step(1'b1, 1'b1, 6'h00, S_R_WB,     O_R_WB,     "r_wb");
        // LW with three stall cycles in MEM_RD: 8 cycles total
        step(1'b1, 1'b1, 6'h23, S_FETCH,    O_FETCH_R,  "lw_fetch");
        step(1'b1, 1'b1, 6'h23, S_DECODE,   O_DECODE,   "lw_decode");
        step(1'b1, 1'b1, 6'h23, S_MEM_ADDR, O_ADDSRC,   "lw_addr");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 6'h23, S_MEM_RD, O_MEM_RD, "lw_rd_wait");
        end
        step(1'b1, 1'b1, 6'h23, S_MEM_RD,   O_MEM_RD,   "lw_rd_ready");
        step(1'b1, 1'b1, 6'h23, S_MEM_WB,   O_MEM_WB,   "lw_wb");
        // SW with two wait cycles
        step(1'b1, 1'b1, 6'h2B, S_FETCH,    O_FETCH_R,  "sw_fetch");
        step(1'b1, 1'b1, 6'h2B, S_DECODE,   O_DECODE,   "sw_decode");
        step(1'b1, 1'b1, 6'h2B, S_MEM_ADDR, O_ADDSRC,   "sw_addr");
        step(1'b1, 1'b0, 6'h2B, S_MEM_WR,   O_MEM_WR_W, "sw_wr_wait0");
        step(1'b1, 1'b0, 6'h2B, S_MEM_WR,   O_MEM_WR_W, "sw_wr_wait1");
        step(1'b1, 1'b1, 6'h2B, S_MEM_WR,   O_MEM_WR_R, "sw_wr_ready");
        // BEQ with one FETCH stall
        step(1'b1, 1'b0, 6'h04, S_FETCH,    O_FETCH_W,  "beq_fetch_wait");
        step(1'b1, 1'b1, 6'h04, S_FETCH,    O_FETCH_R,  "beq_fetch");
        step(1'b1, 1'b1, 6'h04, S_DECODE,   O_DECODE,   "beq_decode");
        step(1'b1, 1'b1, 6'h04, S_BR_EXEC,  O_BR,       "beq_exec");
        // J: 3 cycles
        step(1'b1, 1'b1, 6'h02, S_FETCH,    O_FETCH_R,  "j_fetch");
        step(1'b1, 1'b1, 6'h02, S_DECODE,   O_DECODE,   "j_decode");
        step(1'b1, 1'b1, 6'h02, S_JUMP,     O_JUMP,     "j_jump");
        // ADDI: 4 cycles
        step(1'b1, 1'b1, 6'h08, S_FETCH,    O_FETCH_R,  "addi_fetch");
        step(1'b1, 1'b1, 6'h08, S_DECODE,   O_DECODE,   "addi_decode");
        step(1'b1, 1'b1, 6'h08, S_I_EXEC,   O_ADDSRC,   "addi_exec");
        step(1'b1, 1'b1, 6'h08, S_I_WB,     O_I_WB,     "addi_wb");
        // Reset asserted mid-cycle while waiting in MEM_WR
        step(1'b1, 1'b1, 6'h2B, S_FETCH,    O_FETCH_R,  "rst_sw_fetch");
        step(1'b1, 1'b1, 6'h2B, S_DECODE,   O_DECODE,   "rst_sw_decode");
        step(1'b1, 1'b1, 6'h2B, S_MEM_ADDR, O_ADDSRC,   "rst_sw_addr");
        step(1'b1, 1'b0, 6'h2B, S_MEM_WR,   O_MEM_WR_W, "rst_sw_wait");
        step(1'b0, 1'b0, 6'h2B, S_IDLE,     O_ZERO,     "rst_abort");
        step(1'b1, 1'b1, 6'h3F, S_IDLE,     O_ZERO,     "rst_release");
        step(1'b1, 1'b1, 6'h3F, S_FETCH,    O_FETCH_R,  "rst_restart_fetch");
        // Unknown opcode
        step(1'b1, 1'b1, 6'h3F, S_DECODE,   O_DECODE,   "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        step(1'b1, 1'b1, 6'h3F, S_TRAP,     O_TRAP,     "ill_trap0");
        step(1'b1, 1'b0, 6'h00, S_TRAP,     O_TRAP,     "ill_trap1");
        step(1'b1, 1'b1, 6'h00, S_TRAP,     O_TRAP,     "ill_trap2");
`else
        step(1'b1, 1'b1, 6'h00, S_FETCH,    O_FETCH_R,  "ill_nop_fetch");
        step(1'b1, 1'b1, 6'h00, S_DECODE,   O_DECODE,   "ill_next_decode");
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle successor to the single-cycle main control decoder.
- Moore FSM that sequences fetch/decode/execute/memory/writeback for R-type, LW, SW, BEQ, ADDI and J.
- Drives the shared datapath (single memory, single ALU). Stalls on a memory-ready handshake.
- Opcode values and widths are parametrised.

Parameters:
OPW, 6, opcode width
ALUC_W, 3, AluC width
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word
OP_SW, 6'h2B, store word
OP_BEQ, 6'h04, branch-equal
OP_ADDI, 6'h08, add immediate
OP_J, 6'h02, jump

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  OPW  IR[31:26]; held stable by the datapath after IRWrite
mem_ready  in  1  memory completes the current access this cycle
BR_En  out  1  register file write enable
AluC  out  ALUC_W  000 = use funct, 001 = add, 010 = sub
EnW  out  1  memory write
EnR  out  1  memory read
Mux1  out  1  writeback select, 0 = ALUOut, 1 = MDR
regDest  out  1  1 = rd, 0 = rt
AluSRC  out  1  ALU B operand, 0 = register, 1 = sign-extended immediate
Branch  out  1  conditional PC write; the datapath ANDs it with Zero
PCWrite  out  1  unconditional PC write
IRWrite  out  1  instruction register load
IorD  out  1  memory address, 0 = PC, 1 = ALUOut
PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
instr_done  out  1  one-cycle pulse in the final state of each instruction
state_o  out  4  current state encoding, for debug
illegal  out  1  illegal-opcode flag; see Optional Feature

Behaviour:
- Outputs are a combinational decode of the registered state, plus mem_ready qualification where noted. No output is asserted unless listed for the state.
- Reset: the state register clears asynchronously to IDLE (0). Every output is 0 in IDLE. Reset asserted mid-instruction aborts the instruction and drops all outputs the same cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, R_EXEC=3, R_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BR_EXEC=9, I_EXEC=10, I_WB=11, JUMP=12, TRAP=13. Unused codes go to FETCH.
- IDLE: go to FETCH.
- FETCH:
  - EnR=1, IorD=0, AluC=001, PCSrc=00.
  - If mem_ready=0, hold FETCH with IRWrite=0 and PCWrite=0.
  - If mem_ready=1, assert IRWrite=1 and PCWrite=1, then go to DECODE.
- DECODE: AluC=001 (branch target precompute). Next state from Opcode:
  - RTYPE to R_EXEC
  - LW or SW to MEM_ADDR
  - BEQ to BR_EXEC
  - ADDI to I_EXEC
  - J to JUMP
  - any other opcode to FETCH (feature off) or TRAP (feature on)
- R_EXEC: AluC=000, AluSRC=0. Go to R_WB.
- R_WB: BR_En=1, regDest=1, Mux1=0, instr_done=1. Go to FETCH.
- MEM_ADDR: AluC=001, AluSRC=1. LW goes to MEM_RD; SW goes to MEM_WR. Opcode is re-evaluated here.
- MEM_RD: EnR=1, IorD=1. Hold while mem_ready=0; go to MEM_WB when mem_ready=1.
- MEM_WB: BR_En=1, Mux1=1, regDest=0, instr_done=1. Go to FETCH.
- MEM_WR:
  - EnW=1 and IorD=1 while waiting.
  - Hold while mem_ready=0.
  - When mem_ready=1, assert instr_done=1 and go to FETCH.
  - EnW stays high for the whole wait.
- BR_EXEC: AluC=010, AluSRC=0, Branch=1, PCSrc=01, instr_done=1. Go to FETCH.
- I_EXEC: AluC=001, AluSRC=1. Go to I_WB.
- I_WB: BR_En=1, regDest=0, Mux1=0, instr_done=1. Go to FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1. Go to FETCH.
- Latency in cycles (FETCH to last state inclusive, mem_ready tied to 1): R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds 1.
- Invariants:
  - EnR and EnW are never high together.
  - BR_En is high only in a WB state.
  - IRWrite is high only in FETCH with mem_ready=1.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. In TRAP, illegal=1 and all other outputs are 0. TRAP is left only by reset.
- Undefined: an unknown opcode goes from DECODE to FETCH as a 2-cycle NOP with no writes and no instr_done. TRAP is unreachable; illegal is tied to 0.

Test Plan:
- Release rst_n, mem_ready=1, Opcode=6'h00 -> IDLE, then FETCH (IRWrite=1, PCWrite=1), then DECODE, R_EXEC (AluC=000), R_WB (BR_En=1, regDest=1). instr_done is high exactly in cycle 4 after FETCH entry.
- Opcode=6'h23, mem_ready low for 3 cycles in MEM_RD -> EnR=1 and IorD=1 held for 4 cycles, then MEM_WB with BR_En=1 and Mux1=1. Total 8 cycles.
- Opcode=6'h2B -> MEM_WR with EnW=1 until mem_ready; BR_En is never asserted. Opcode=6'h04 -> BR_EXEC with Branch=1, AluC=010, PCSrc=01.
- Opcode=6'h02 -> JUMP with PCWrite=1, PCSrc=10, 3 cycles total. Opcode=6'h08 -> I_WB with BR_En=1, regDest=0, AluSRC=1 in I_EXEC.
- Assert rst_n=0 while in MEM_WR with mem_ready=0 -> all outputs 0 in the same cycle, state_o=0. After release, the FSM restarts at FETCH.
- Opcode=6'h3F -> with CTRL_ILLEGAL_TRAP_EN: TRAP with illegal=1, stuck until reset. Without it: FETCH on the cycle after DECODE, no write enables asserted.
